// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: session controller that arms, fills, and slides a serial pattern window, reporting matches, timeouts and done.
module seq_detect_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WIDTH-1:0]         cfg_code,
  input  logic [$clog2(WIDTH):0]   cfg_len,
  input  logic                     cfg_oneshot,
  input  logic [TMO_W-1:0]         cfg_timeout,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic                     done,
  output logic                     timed_out
);
  localparam int LW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, FILL, SEARCH} state_t;
  state_t state;
  logic [WIDTH-1:0] code, window, mask, ext;
  logic [LW-1:0] len, fill_cnt, new_len, start_len;
  logic [TMO_W-1:0] timeout, miss_cnt;
  logic oneshot, hs, hit, tmo_hit;
  assign busy = state != IDLE;
  assign cfg_ready = state == IDLE;
  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign mask[i] = LW'(i) < len;
  end
  always_comb begin
    hs = cfg_valid && state == IDLE;
    new_len = cfg_len == '0 ? LW'(1) : cfg_len > LW'(WIDTH) ? LW'(WIDTH) : cfg_len;
    start_len = hs ? new_len : len;
    ext = {window[WIDTH-2:0], din};
    hit = ((ext ^ code) & mask) == '0;
    tmo_hit = timeout != '0 && miss_cnt == timeout - TMO_W'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      code <= '0;
      len <= LW'(WIDTH);
      oneshot <= 1'b0;
      timeout <= '0;
      window <= '0;
      fill_cnt <= '0;
      miss_cnt <= '0;
      match_count <= '0;
      match <= 1'b0;
      done <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      match <= 1'b0;
      done <= 1'b0;
      if (hs) begin
        code <= cfg_code;
        len <= new_len;
        oneshot <= cfg_oneshot;
        timeout <= cfg_timeout;
      end
      case (state)
        IDLE: if (start && !abort) begin
          state <= start_len == LW'(1) ? SEARCH : FILL;
          window <= '0;
          fill_cnt <= '0;
          miss_cnt <= '0;
          match_count <= '0;
          timed_out <= 1'b0;
        end
        FILL: if (abort) state <= IDLE;
        else begin
          window <= ext;
          fill_cnt <= fill_cnt + LW'(1);
          if (fill_cnt == len - LW'(2)) state <= SEARCH;
        end
        SEARCH: if (abort) state <= IDLE;
        else begin
          window <= ext;
          if (hit) begin
            match <= 1'b1;
            match_count <= &match_count ? match_count : match_count + CNT_W'(1);
            miss_cnt <= '0;
            if (oneshot) begin
              state <= IDLE;
              done <= 1'b1;
            end
          end else if (timeout != '0) begin
            miss_cnt <= &miss_cnt ? miss_cnt : miss_cnt + TMO_W'(1);
            if (tmo_hit) begin
              state <= IDLE;
              timed_out <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: table-driven scoreboard bench for seq_detect_ctrl (CNT_W=2 to reach saturation quickly).
module tb_seq_detect_ctrl;
  logic clk = 0, reset = 1, din = 0, cfg_valid = 0, cfg_ready, cfg_oneshot = 0;
  logic start = 0, abort = 0, busy, match, done, timed_out;
  logic [3:0] cfg_code = 0;
  logic [2:0] cfg_len = 0;
  logic [15:0] cfg_timeout = 0;
  logic [1:0] match_count;
  int tests = 0, fails = 0;

  seq_detect_ctrl #(.WIDTH(4), .CNT_W(2), .TMO_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_code(cfg_code), .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .busy(busy), .match(match), .match_count(match_count),
    .done(done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic din, start, abort, cv;
    logic m, d, b, t;
    logic [1:0] cnt;
    string name;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t v(logic di, st, ab, cv, m, d, b, t, logic [1:0] cnt, string name);
    vec_t r;
    r.din = di; r.start = st; r.abort = ab; r.cv = cv;
    r.m = m; r.d = d; r.b = b; r.t = t; r.cnt = cnt; r.name = name;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setcfg(logic [3:0] c, logic [2:0] l, logic os, logic [15:0] tmo);
    cfg_code = c; cfg_len = l; cfg_oneshot = os; cfg_timeout = tmo;
  endtask

  task automatic run_tbl();
    vec_t e;
    foreach (tbl[i]) begin
      din = tbl[i].din; start = tbl[i].start; abort = tbl[i].abort; cfg_valid = tbl[i].cv;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      chk({e.name, ".match"}, match, e.m);
      chk({e.name, ".done"}, done, e.d);
      chk({e.name, ".busy"}, busy, e.b);
      chk({e.name, ".ready"}, cfg_ready, !e.b);
      chk({e.name, ".timed_out"}, timed_out, e.t);
      chk({e.name, ".count"}, match_count, e.cnt);
    end
    tbl.delete();
    din = 0; start = 0; abort = 0; cfg_valid = 0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.ready", cfg_ready, 1);
    chk("rst.match", match, 0);
    chk("rst.done", done, 0);
    chk("rst.timed_out", timed_out, 0);
    chk("rst.count", match_count, 0);
    reset = 0;
    tick();

    // continuous 1010, overlapping second hit, abort wins over a simultaneous hit
    setcfg(4'b1010, 3'd4, 0, 16'd0);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "t1_start"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "t1_c1"));
    tbl.push_back(v(0,0,0,0, 0,0,1,0,0, "t1_c2"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "t1_c3"));
    tbl.push_back(v(0,0,0,0, 1,0,1,0,1, "t1_c4"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,1, "t1_c5"));
    tbl.push_back(v(0,0,0,0, 1,0,1,0,2, "t1_c6"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,2, "t1_c7"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,2, "t1_abort"));
    run_tbl();

    setcfg(4'b1010, 3'd4, 1, 16'd0);
    tbl.push_back(v(0,0,0,1, 0,0,0,0,2, "t3_cfg"));
    tbl.push_back(v(0,1,0,0, 0,0,1,0,0, "t3_start"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "t3_c1"));
    tbl.push_back(v(0,0,0,0, 0,0,1,0,0, "t3_c2"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "t3_c3"));
    tbl.push_back(v(0,0,0,0, 1,1,0,0,1, "t3_hit"));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,1, "t3_post1"));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1, "t3_post2"));
    tbl.push_back(v(1,0,0,0, 0,0,0,0,1, "t3_post3"));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,1, "t3_post4"));
    run_tbl();

    setcfg(4'b0111, 3'd3, 0, 16'd5);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "t4_start"));
    for (int i = 1; i <= 6; i++) tbl.push_back(v(0,0,0,0, 0,0,1,0,0, $sformatf("t4_c%0d", i)));
    tbl.push_back(v(0,0,0,0, 0,1,0,1,0, "t4_tmo"));
    tbl.push_back(v(0,0,0,0, 0,0,0,1,0, "t4_hold"));
    tbl.push_back(v(0,1,0,0, 0,0,1,0,0, "t4_restart"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,0, "t4_abort"));
    run_tbl();

    setcfg(4'b1010, 3'd4, 0, 16'd0);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "t5_start"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "t5_c1"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,0, "t5_abort"));
    tbl.push_back(v(0,0,0,1, 0,0,0,0,0, "t5_cfg"));
    tbl.push_back(v(0,1,1,0, 0,0,0,0,0, "t5_idle_abort"));
    run_tbl();

    setcfg(4'b0001, 3'd1, 0, 16'd0);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "t6_start"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,1, "t6_m1"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,2, "t6_m2"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,3, "t6_m3"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,3, "t6_sat"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,3, "t6_abort"));
    run_tbl();

    setcfg(4'b0001, 3'd0, 0, 16'd0);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "len0_start"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,1, "len0_m"));
    tbl.push_back(v(0,0,0,0, 0,0,1,0,1, "len0_miss"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,1, "len0_abort"));
    run_tbl();

    setcfg(4'b1010, 3'd7, 0, 16'd0);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "len7_start"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "len7_c1"));
    tbl.push_back(v(0,0,0,0, 0,0,1,0,0, "len7_c2"));
    tbl.push_back(v(1,0,0,0, 0,0,1,0,0, "len7_c3"));
    tbl.push_back(v(0,0,0,0, 1,0,1,0,1, "len7_hit"));
    tbl.push_back(v(0,0,1,0, 0,0,0,0,1, "len7_abort"));
    run_tbl();

    // timeout=1 means the first miss ends the session; hits must keep it alive
    setcfg(4'b0001, 3'd1, 0, 16'd1);
    tbl.push_back(v(0,1,0,1, 0,0,1,0,0, "hvt_start"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,1, "hvt_h1"));
    tbl.push_back(v(1,0,0,0, 1,0,1,0,2, "hvt_h2"));
    tbl.push_back(v(0,0,0,0, 0,1,0,1,2, "hvt_miss"));
    run_tbl();

    setcfg(4'b0001, 3'd1, 0, 16'd0);
    cfg_valid = 1; start = 1;
    tick();
    cfg_valid = 0; start = 0; din = 1;
    tick();
    tick();
    chk("mrst.pre_count", match_count, 2);
    #3 reset = 1;
    #1;
    chk("mrst.busy", busy, 0);
    chk("mrst.ready", cfg_ready, 1);
    chk("mrst.count", match_count, 0);
    chk("mrst.match", match, 0);
    @(posedge clk);
    #1 reset = 0; din = 0;
    tick();
    chk("mrst.done", done, 0);
    chk("mrst.busy_after", busy, 0);

    setcfg(4'b0011, 3'd2, 0, 16'd3);
    cfg_valid = 1; start = 1;
    tick();
    cfg_valid = 0; start = 0; din = 0;
    n = 0;
    while (n < 20 && !done) begin
      tick();
      n++;
    end
    chk("t7_done_seen", done, 1);
    chk("t7_latency", n, 4);
    chk("t7_timed_out", timed_out, 1);
    chk("t7_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
